// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls words from an upstream FIFO and sends them as 8N1-style UART frames.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   enable     allows a new frame to start (only looked at in IDLE)
//   fifo_empty upstream FIFO empty flag
//   fifo_data  upstream registered read data, valid the cycle after fifo_rd_en
//   fifo_rd_en one-cycle read strobe (the FETCH cycle)
//   tx         serial line, idle high
//   busy       high whenever the FSM is not in IDLE
//   tx_done    pulse on the last cycle of the stop bit
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module fifo_uart_tx #(
  parameter int DWIDTH = 7,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            fifo_empty,
  input  logic [DWIDTH:0] fifo_data,
  output logic            fifo_rd_en,
  output logic            tx,
  output logic            busy,
  output logic            tx_done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = DWIDTH > 0 ? $clog2(DWIDTH + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH);
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [DWIDTH:0] shreg;
  logic armed, bit_end, tx_n;
  assign bit_end = cnt == LAST;
  always_comb begin
    state_n = state;
    bit_n = bit_cnt;
    case (state)
      IDLE:  state_n = enable && !fifo_empty && armed ? FETCH : IDLE;
      FETCH: state_n = LOAD;
      LOAD:  state_n = START;
      START: if (bit_end) begin
        state_n = DATA;
        bit_n = '0;
      end
      DATA: if (bit_end) begin
        if (bit_cnt == LAST_BIT)
`ifdef FIFO_UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        else
          bit_n = bit_cnt + 1'b1;
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: state_n = bit_end ? STOP : PARITY;
`endif
      STOP:  state_n = bit_end ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    cnt_n = !(state inside {IDLE, FETCH, LOAD}) && !bit_end ? cnt + 1'b1 : '0;
`ifdef FIFO_UART_TX_PARITY_EN
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg[bit_n] : state_n == PARITY ? ^shreg : 1'b1;
`else
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg[bit_n] : 1'b1;
`endif
  end
  // Outputs are registered from next-state values so they line up with the state they describe.
  // armed holds off the first FETCH until the second edge after reset release.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      armed <= 1'b0;
      tx <= 1'b1;
      busy <= 1'b0;
      fifo_rd_en <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      armed <= 1'b1;
      if (state == LOAD) shreg <= fifo_data;
      tx <= tx_n;
      busy <= state_n != IDLE;
      fifo_rd_en <= state_n == FETCH;
      tx_done <= state_n == STOP && cnt_n == LAST;
    end
endmodule
